// File: rtl/lake_spec_pkg.sv
// lake_spec_pkg: mode enum, per-port config struct and
// config-map bit offsets shared by the lake_spec tile.
package lake_spec_pkg;

  typedef enum logic {
    STATIC = 1'b0,
    LI     = 1'b1
  } mode_e;

  typedef struct packed {
    logic [15:0] ext0;
    logic [15:0] ext1;
    logic [15:0] stride0;
    logic [15:0] stride1;
    logic [15:0] offset;
    logic [15:0] start_delay;
  } port_cfg_t;

  localparam int MODE_BIT = 0;
  localparam int W_BASE   = 1;
  localparam int R_BASE   = 97;
  localparam int BLK_W    = 96;
  localparam int CFG_USED = 193;

  localparam int OFF_EXT0    = 0;
  localparam int OFF_EXT1    = 16;
  localparam int OFF_STRIDE0 = 32;
  localparam int OFF_STRIDE1 = 48;
  localparam int OFF_OFFSET  = 64;
  localparam int OFF_SDELAY  = 80;

  function automatic port_cfg_t get_cfg(
    input logic [BLK_W-1:0] b
  );
    port_cfg_t c;
    c.ext0        = b[OFF_EXT0 +: 16];
    c.ext1        = b[OFF_EXT1 +: 16];
    c.stride0     = b[OFF_STRIDE0 +: 16];
    c.stride1     = b[OFF_STRIDE1 +: 16];
    c.offset      = b[OFF_OFFSET +: 16];
    c.start_delay = b[OFF_SDELAY +: 16];
    return c;
  endfunction

endpackage

// File: rtl/lake_spec_addr_gen.sv
// lake_spec_addr_gen: 2-D affine iterator. Ports: clk, rst_n,
// flush, cfg, step (transfer this cycle) -> addr, done.
module lake_spec_addr_gen
  import lake_spec_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  port_cfg_t     cfg,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          done
);

  logic [15:0] i0;
  logic [15:0] i1;
  logic [15:0] acc0;
  logic [15:0] acc1;
  logic [15:0] full;
  logic        fin;
  logic        last0;
  logic        last1;
  logic        unused_ok;

  assign last0 = i0 == cfg.ext0 - 16'd1;
  assign last1 = i1 == cfg.ext1 - 16'd1;

  // Running products i*stride avoid multipliers;
  // mod 2^16 then low AW bits equals mod MEM_DEPTH.
  assign full = cfg.offset + acc0 + acc1;
  assign addr = full[AW-1:0];

  assign done = fin
              | (cfg.ext0 == 16'd0)
              | (cfg.ext1 == 16'd0);

  assign unused_ok = ^{full[15:AW], cfg.start_delay};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i0   <= '0;
      i1   <= '0;
      acc0 <= '0;
      acc1 <= '0;
      fin  <= 1'b0;
    end else if (flush) begin
      i0   <= '0;
      i1   <= '0;
      acc0 <= '0;
      acc1 <= '0;
      fin  <= 1'b0;
    end else if (step && !done) begin
      if (last0) begin
        i0   <= '0;
        acc0 <= '0;
        if (last1) begin
          fin <= 1'b1;
        end else begin
          i1   <= i1 + 16'd1;
          acc1 <= acc1 + cfg.stride1;
        end
      end else begin
        i0   <= i0 + 16'd1;
        acc0 <= acc0 + cfg.stride0;
      end
    end
  end

endmodule

// File: rtl/lake_spec.sv
// lake_spec: 1W/1R memory tile, static schedule or LI flow.
// Ports: clk, rst_n, flush, config_memory, port_0*/port_1*.
module lake_spec
  import lake_spec_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int CONFIG_MEMORY_SIZE = 512,
  parameter int MEM_DEPTH          = 512,
  parameter int NUMBER_PORTS       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
  input  logic [DATA_WIDTH-1:0]         port_0,
  input  logic                          port_0_valid,
  output logic                          port_0_ready,
  output logic [DATA_WIDTH-1:0]         port_1,
  output logic                          port_1_valid,
  input  logic                          port_1_ready
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH = OW'(MEM_DEPTH);

  mode_e           mode;
  port_cfg_t       wcfg;
  port_cfg_t       rcfg;
  logic [15:0]     t;
  logic [OW-1:0]   occ;
  logic [AW-1:0]   waddr;
  logic [AW-1:0]   raddr;
  logic            wdone;
  logic            rdone;
  logic            w_ok;
  logic            r_ok;
  logic            wfire;
  logic            rfire;
  logic            unused_ok;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign mode = mode_e'(config_memory[MODE_BIT]);
  assign wcfg = get_cfg(config_memory[W_BASE +: BLK_W]);
  assign rcfg = get_cfg(config_memory[R_BASE +: BLK_W]);

  assign unused_ok = ^{
    config_memory[CONFIG_MEMORY_SIZE-1:CFG_USED],
    NUMBER_PORTS[0]
  };

  lake_spec_addr_gen #(.AW(AW)) u_wgen (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .cfg   (wcfg),
    .step  (wfire),
    .addr  (waddr),
    .done  (wdone)
  );

  lake_spec_addr_gen #(.AW(AW)) u_rgen (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .cfg   (rcfg),
    .step  (rfire),
    .addr  (raddr),
    .done  (rdone)
  );

  // rst_n gates the handshakes directly so they drop
  // the moment reset asserts, not at the next edge.
  always_comb begin
    w_ok = 1'b0;
    r_ok = 1'b0;
    if (rst_n && !flush) begin
      unique case (mode)
        LI: begin
          w_ok = !wdone && (occ < DEPTH);
          r_ok = !rdone && (occ != '0);
        end
        STATIC: begin
          w_ok = !wdone && (t >= wcfg.start_delay);
          r_ok = !rdone && (t >= rcfg.start_delay);
        end
      endcase
    end
  end

  assign wfire = w_ok && (mode == STATIC || port_0_valid);
  assign rfire = r_ok && (mode == STATIC || port_1_ready);

  assign port_0_ready = w_ok;
  assign port_1_valid = r_ok;
  assign port_1       = r_ok ? mem[raddr] : '0;

  always_ff @(posedge clk) begin
    if (wfire) begin
      mem[waddr] <= port_0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t   <= '0;
      occ <= '0;
    end else if (flush) begin
      t   <= '0;
      occ <= '0;
    end else begin
      if (t != 16'hFFFF) begin
        t <= t + 16'd1;
      end
      unique case ({wfire, rfire})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_lake_spec.sv
// tb_lake_spec: directed self-checking bench for lake_spec.
// One task per scenario, hand-computed expectations.
module tb_lake_spec;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [511:0] config_memory;
  logic [15:0]  port_0;
  logic         port_0_valid;
  logic         port_0_ready;
  logic [15:0]  port_1;
  logic         port_1_valid;
  logic         port_1_ready;

  int n_run  = 0;
  int n_fail = 0;

  lake_spec dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .config_memory (config_memory),
    .port_0        (port_0),
    .port_0_valid  (port_0_valid),
    .port_0_ready  (port_0_ready),
    .port_1        (port_1),
    .port_1_valid  (port_1_valid),
    .port_1_ready  (port_1_ready)
  );

  always #5 clk = ~clk;

  // Block layout: ext0 low 16 bits ... start_delay high.
  function automatic logic [95:0] blk(
    input logic [15:0] e0, e1, s0, s1, off, sd
  );
    return {sd, off, s1, s0, e1, e0};
  endfunction

  function automatic logic [511:0] mk(
    input logic li,
    input logic [95:0] w,
    input logic [95:0] r
  );
    logic [511:0] c;
    c = '0;
    c[0] = li;
    c[96:1] = w;
    c[192:97] = r;
    return c;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle t=0.
  task automatic start_seq(input logic [511:0] cfg);
    config_memory = cfg;
    port_0 = '0;
    port_0_valid = 1'b0;
    port_1_ready = 1'b0;
    flush = 1'b1;
    next_cycle();
    next_cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [511:0] cfg;
    cfg = mk(1'b1, blk(16'd4, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0),
             blk(16'd4, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0));
    config_memory = cfg;
    rst_n = 1'b0;
    flush = 1'b0;
    port_0 = 16'h1234;
    port_0_valid = 1'b1;
    port_1_ready = 1'b1;
    next_cycle();
    #1;
    n_run++;
    if (port_0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready got %b exp 0", port_0_ready);
    end
    n_run++;
    if (port_1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b exp 0", port_1_valid);
    end
    n_run++;
    if (port_1 !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_data got %h exp 0", port_1);
    end
    next_cycle();
    rst_n = 1'b1;
    flush = 1'b1;
    next_cycle();
    #1;
    n_run++;
    if (port_0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready got %b exp 0", port_0_ready);
    end
  endtask

  task automatic test_static();
    logic exp_r, exp_v;
    logic [15:0] exp_d;
    start_seq(mk(1'b0,
      blk(16'd64, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0),
      blk(16'd64, 16'd1, 16'd1, 16'd0, 16'd0, 16'd8)));
    for (int c = 0; c < 76; c++) begin
      port_0 = 16'(2 * c);
      #1;
      exp_r = c < 64;
      exp_v = (c >= 8) && (c < 72);
      exp_d = exp_v ? 16'(2 * (c - 8)) : 16'h0;
      n_run++;
      if (port_0_ready !== exp_r) begin
        n_fail++;
        $display("FAIL st_ready c=%0d got %b exp %b",
                 c, port_0_ready, exp_r);
      end
      n_run++;
      if (port_1_valid !== exp_v) begin
        n_fail++;
        $display("FAIL st_valid c=%0d got %b exp %b",
                 c, port_1_valid, exp_v);
      end
      n_run++;
      if (port_1 !== exp_d) begin
        n_fail++;
        $display("FAIL st_data c=%0d got %0d exp %0d",
                 c, port_1, exp_d);
      end
      next_cycle();
    end
  endtask

  task automatic test_li_stall();
    logic exp_r, exp_v;
    logic [15:0] exp_d;
    start_seq(mk(1'b1,
      blk(16'd64, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0),
      blk(16'd64, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0)));
    port_0_valid = 1'b1;
    for (int c = 0; c < 132; c++) begin
      port_0 = 16'(2 * c);
      port_1_ready = c >= 65;
      #1;
      exp_r = c < 64;
      exp_v = (c >= 1) && (c <= 128);
      exp_d = (c >= 65 && c <= 128) ? 16'(2 * (c - 65))
            : (c >= 1 && c <= 64) ? 16'h0 : 16'h0;
      n_run++;
      if (port_0_ready !== exp_r) begin
        n_fail++;
        $display("FAIL li_ready c=%0d got %b exp %b",
                 c, port_0_ready, exp_r);
      end
      n_run++;
      if (port_1_valid !== exp_v) begin
        n_fail++;
        $display("FAIL li_valid c=%0d got %b exp %b",
                 c, port_1_valid, exp_v);
      end
      if (c >= 65) begin
        n_run++;
        if (port_1 !== exp_d) begin
          n_fail++;
          $display("FAIL li_data c=%0d got %0d exp %0d",
                   c, port_1, exp_d);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_li_full();
    logic exp_r;
    start_seq(mk(1'b1,
      blk(16'd600, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0),
      blk(16'd600, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0)));
    port_0_valid = 1'b1;
    for (int c = 0; c < 533; c++) begin
      port_0 = 16'(c + 100);
      port_1_ready = c == 530;
      #1;
      exp_r = (c < 512) || (c == 531);
      n_run++;
      if (port_0_ready !== exp_r) begin
        n_fail++;
        $display("FAIL full_ready c=%0d got %b exp %b",
                 c, port_0_ready, exp_r);
      end
      if (c == 530 || c == 531) begin
        n_run++;
        if (port_1 !== 16'(c - 430)) begin
          n_fail++;
          $display("FAIL full_data c=%0d got %0d exp %0d",
                   c, port_1, c - 430);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_li_2d();
    logic [15:0] tbl [8];
    logic exp_v;
    tbl = '{16'd0, 16'd4, 16'd8, 16'd12,
            16'd2, 16'd6, 16'd10, 16'd14};
    start_seq(mk(1'b1,
      blk(16'd8, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0),
      blk(16'd4, 16'd2, 16'd2, 16'd1, 16'd0, 16'd0)));
    port_0_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      port_0 = 16'(2 * c);
      port_1_ready = c >= 10;
      #1;
      exp_v = (c >= 1) && (c <= 17);
      n_run++;
      if (port_1_valid !== exp_v) begin
        n_fail++;
        $display("FAIL ag_valid c=%0d got %b exp %b",
                 c, port_1_valid, exp_v);
      end
      if (c == 8) begin
        n_run++;
        if (port_0_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ag_wdone got %b exp 0", port_0_ready);
        end
      end
      if (c >= 10 && c <= 17) begin
        n_run++;
        if (port_1 !== tbl[c-10]) begin
          n_fail++;
          $display("FAIL ag_data c=%0d got %0d exp %0d",
                   c, port_1, tbl[c-10]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    logic [511:0] cfg;
    cfg = mk(1'b0,
      blk(16'd64, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0),
      blk(16'd64, 16'd1, 16'd1, 16'd0, 16'd0, 16'd8));
    start_seq(cfg);
    for (int c = 0; c < 20; c++) begin
      port_0 = 16'(5 * c);
      next_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (port_0_ready !== 1'b0 || port_1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_hs got r=%b v=%b exp 0 0",
               port_0_ready, port_1_valid);
    end
    n_run++;
    if (port_1 !== 16'h0) begin
      n_fail++;
      $display("FAIL arst_data got %h exp 0", port_1);
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    start_seq(cfg);
    for (int c = 0; c < 10; c++) begin
      port_0 = 16'(3 * c + 1);
      #1;
      n_run++;
      if (port_1_valid !== (c >= 8)) begin
        n_fail++;
        $display("FAIL rs_valid c=%0d got %b exp %b",
                 c, port_1_valid, c >= 8);
      end
      if (c == 0) begin
        n_run++;
        if (port_0_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rs_ready got %b exp 1", port_0_ready);
        end
      end
      if (c >= 8) begin
        n_run++;
        if (port_1 !== 16'(3 * (c - 8) + 1)) begin
          n_fail++;
          $display("FAIL rs_data c=%0d got %0d exp %0d",
                   c, port_1, 3 * (c - 8) + 1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_ext_zero();
    start_seq(mk(1'b1,
      blk(16'd4, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0),
      blk(16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0)));
    port_0_valid = 1'b1;
    port_1_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      port_0 = 16'(c + 7);
      #1;
      n_run++;
      if (port_0_ready !== (c < 4)) begin
        n_fail++;
        $display("FAIL ez_ready c=%0d got %b exp %b",
                 c, port_0_ready, c < 4);
      end
      n_run++;
      if (port_1_valid !== 1'b0 || port_1 !== 16'h0) begin
        n_fail++;
        $display("FAIL ez_read c=%0d got v=%b d=%h exp 0 0",
                 c, port_1_valid, port_1);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_li_stall();
    test_li_full();
    test_li_2d();
    test_async_reset();
    test_ext_zero();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
